// File: rtl/mem_pkg.sv
// Shared encodings for the unified memory: request opcodes and controller states.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_RD  = 2'b01,
        OP_WR  = 2'b10,
        OP_INV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM with per-byte write enables; a read registers the addressed word.
module mem_array #(
    parameter int N     = 32,
    parameter int DEPTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            i_en,
    input  logic            i_we,
    input  logic [AW-1:0]   i_idx,
    input  logic [N-1:0]    i_wdata,
    input  logic [N/8-1:0]  i_be,
    output logic [N-1:0]    o_rdata
);

    logic [N-1:0] r_mem [DEPTH];
    logic [N-1:0] r_rdata;

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < N/8; i++) begin
                    if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end else begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/unified_memory.sv
// Unified instruction/data memory: request latch, error decode, wait-state FSM around mem_array.
module unified_memory
    import mem_pkg::*;
#(
    parameter int N      = 32,
    parameter int ADDR_W = 6,
    parameter int WAIT   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  logic            inst_data,
    input  logic [1:0]      opType,
    input  logic [N-1:0]    addr,
    input  logic [N-1:0]    wdata,
    input  logic [N/8-1:0]  byte_en,
    output logic [N-1:0]    rdata,
    output logic            ready,
    output logic            busy,
    output logic            err
);

    localparam int         DEPTH     = 2 ** (ADDR_W + 1);
    localparam logic [3:0] WAIT_LAST = 4'((WAIT > 0) ? WAIT - 1 : 0);

    state_e             r_state, w_next;
    logic [3:0]         r_cnt;
    logic [ADDR_W:0]    r_idx;
    logic [N-1:0]       r_wdata;
    logic [N/8-1:0]     r_be;
    logic [1:0]         r_op;
    logic               r_err;

    logic               w_in_idle, w_accept, w_err_in, w_wait_done;
    logic               w_ram_en, w_ram_we;
    logic [ADDR_W:0]    w_ram_idx;
    logic [N-1:0]       w_ram_wdata, w_ram_rdata;
    logic [N/8-1:0]     w_ram_be;
    logic               w_unused_addr;

    assign w_unused_addr = ^addr[N-1:ADDR_W+2];

    assign w_in_idle   = (r_state == ST_IDLE);
    assign w_accept    = w_in_idle && req && (opType != OP_NOP);
    assign w_err_in    = (opType == OP_INV) || (addr[1:0] != 2'b00);
    assign w_wait_done = (r_state == ST_WAIT) && (r_cnt == WAIT_LAST);

    // With no wait states the access happens on the acceptance edge, so live inputs feed the RAM.
    assign w_ram_en    = !rst && ((w_accept && !w_err_in && (WAIT == 0)) || w_wait_done);
    assign w_ram_we    = w_in_idle ? opType[1] : r_op[1];
    assign w_ram_idx   = w_in_idle ? {inst_data, addr[ADDR_W+1:2]} : r_idx;
    assign w_ram_wdata = w_in_idle ? wdata : r_wdata;
    assign w_ram_be    = w_in_idle ? byte_en : r_be;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = (w_err_in || (WAIT == 0)) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (w_wait_done) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        rdata = '0;
        busy  = (r_state != ST_IDLE);
        if (r_state == ST_RESP) begin
            ready = 1'b1;
            err   = r_err;
            if (!r_err && (r_op == OP_RD)) rdata = w_ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                      r_cnt <= '0;
        else if (w_accept)            r_cnt <= '0;
        else if (r_state == ST_WAIT)  r_cnt <= r_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= {inst_data, addr[ADDR_W+1:2]};
            r_wdata <= wdata;
            r_be    <= byte_en;
            r_op    <= opType;
            r_err   <= w_err_in;
        end
    end

    mem_array #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_idx   (w_ram_idx),
        .i_wdata (w_ram_wdata),
        .i_be    (w_ram_be),
        .o_rdata (w_ram_rdata)
    );

endmodule

// File: tb/tb_unified_memory.sv
// Directed bench: default build (WAIT=2) plus a WAIT=0 build for back-to-back requests.
module tb_unified_memory;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, inst_data = 1'b0;
    logic [1:0]  opType = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] rdata;
    logic        ready, busy, err;

    logic        req2 = 1'b0, inst2 = 1'b0;
    logic [1:0]  op2 = 2'b00;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [3:0]  be2 = '0;
    logic [31:0] rdata2;
    logic        ready2, busy2, err2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    unified_memory #(.N(32), .ADDR_W(6), .WAIT(2)) dut (
        .clk(clk), .rst(rst), .req(req), .inst_data(inst_data), .opType(opType),
        .addr(addr), .wdata(wdata), .byte_en(byte_en),
        .rdata(rdata), .ready(ready), .busy(busy), .err(err)
    );

    unified_memory #(.N(32), .ADDR_W(6), .WAIT(0)) dut0 (
        .clk(clk), .rst(rst), .req(req2), .inst_data(inst2), .opType(op2),
        .addr(addr2), .wdata(wdata2), .byte_en(be2),
        .rdata(rdata2), .ready(ready2), .busy(busy2), .err(err2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic inst, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be,
                          output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        inst_data = inst; opType = op; addr = a; wdata = wd; byte_en = be; req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0; opType = 2'b00; addr = 32'h3C; wdata = '0; byte_en = '0; inst_data = ~inst;
        lat = 0; rd = '0; e = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (ready) begin
                lat = n; rd = rdata; e = err;
                break;
            end
        end
        @(negedge clk);
        check("ready_after_resp", {31'b0, ready}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    logic        e;
    int          pulses;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_busy",  {31'b0, busy},  32'd0);
        check("rst_err",   {31'b0, err},   32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        do_req(1'b0, 2'b10, 32'h08, 32'hDEADBEEF, 4'hF, lat, rd, e);
        check("wr_lat", lat, 32'd3);
        check("wr_err", {31'b0, e}, 32'd0);
        check("wr_rdata_zero", rd, 32'd0);
        do_req(1'b0, 2'b01, 32'h08, 32'h0, 4'h0, lat, rd, e);
        check("rd_lat", lat, 32'd3);
        check("rd_data", rd, 32'hDEADBEEF);

        do_req(1'b1, 2'b10, 32'h08, 32'h11111111, 4'hF, lat, rd, e);
        do_req(1'b0, 2'b01, 32'h08, 32'h0, 4'h0, lat, rd, e);
        check("data_region_kept", rd, 32'hDEADBEEF);
        do_req(1'b1, 2'b01, 32'h08, 32'h0, 4'h0, lat, rd, e);
        check("inst_region", rd, 32'h11111111);

        do_req(1'b0, 2'b10, 32'h08, 32'h0000AB00, 4'b0010, lat, rd, e);
        do_req(1'b0, 2'b01, 32'h08, 32'h0, 4'h0, lat, rd, e);
        check("partial_write", rd, 32'hDEADABEF);

        do_req(1'b0, 2'b11, 32'h08, 32'hFFFFFFFF, 4'hF, lat, rd, e);
        check("inv_lat", lat, 32'd1);
        check("inv_err", {31'b0, e}, 32'd1);
        check("inv_rdata", rd, 32'd0);
        do_req(1'b0, 2'b10, 32'h0A, 32'h00000000, 4'hF, lat, rd, e);
        check("misalign_lat", lat, 32'd1);
        check("misalign_err", {31'b0, e}, 32'd1);
        do_req(1'b0, 2'b10, 32'h08, 32'hFFFFFFFF, 4'h0, lat, rd, e);
        do_req(1'b0, 2'b01, 32'h08, 32'h0, 4'h0, lat, rd, e);
        check("no_change_after_err_be0", rd, 32'hDEADABEF);
        check("rd_err_clear", {31'b0, e}, 32'd0);

        @(negedge clk);
        req = 1'b1; opType = 2'b00; addr = 32'h08;
        @(negedge clk);
        check("nop_ignored", {31'b0, busy}, 32'd0);
        req = 1'b0;

        do_req(1'b0, 2'b10, 32'h10, 32'hCAFEF00D, 4'hF, lat, rd, e);
        @(negedge clk);
        inst_data = 1'b0; opType = 2'b10; addr = 32'h10; wdata = 32'h12345678; byte_en = 4'hF; req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        check("busy_in_wait", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_ready", {31'b0, ready}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check("abort_no_pulse", pulses, 32'd0);
        do_req(1'b0, 2'b01, 32'h10, 32'h0, 4'h0, lat, rd, e);
        check("abort_no_write", rd, 32'hCAFEF00D);

        @(negedge clk);
        inst2 = 1'b0; op2 = 2'b10; addr2 = 32'h04; wdata2 = 32'hA5A5A5A5; be2 = 4'hF; req2 = 1'b1;
        @(posedge clk);
        #1 req2 = 1'b0;
        @(negedge clk);
        check("w0_wr_ready", {31'b0, ready2}, 32'd1);
        check("w0_wr_err", {31'b0, err2}, 32'd0);
        op2 = 2'b01; req2 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("w0_ready_toggle", {31'b0, ready2}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check("w0_busy_toggle",  {31'b0, busy2},  (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 1) check("w0_rdata", rdata2, 32'hA5A5A5A5);
        end
        req2 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/unified_memory.md
UNIFIED_MEMORY -- requirements
Module: unified_memory

Interface
REQ-001 Parameter N, default 32: data and address width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 6: word-index width per region; each region holds 2^ADDR_W words.
REQ-003 Parameter WAIT, default 2: wait-state count inserted before each valid response; range 0..15.
REQ-004 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1: synchronous, active-high reset.
REQ-006 req  input  1: request strobe, sampled only in IDLE.
REQ-007 inst_data  input  1: region select; 1 = instruction region, 0 = data region.
REQ-008 opType  input  2: bit1 = write, bit0 = read; 00 = no-op, 11 = invalid.
REQ-009 addr  input  N: byte address.
REQ-010 wdata  input  N: write data.
REQ-011 byte_en  input  N/8: write byte-lane enables; lane i covers wdata[8i+7:8i].
REQ-012 rdata  output  N: read data; valid only while ready = 1.
REQ-013 ready  output  1: one-cycle completion pulse.
REQ-014 busy  output  1: high whenever the state is not IDLE.
REQ-015 err  output  1: error flag; valid only while ready = 1.

Function
REQ-016 The storage array SHALL be 2^(ADDR_W+1) words, indexed by {inst_data, addr[ADDR_W+1:2]}.
REQ-017 The FSM SHALL use exactly three states: IDLE, WAIT, RESP.
REQ-018 A request SHALL be accepted on an edge where state = IDLE, req = 1 and opType != 00; the edge SHALL latch inst_data, opType, addr, wdata and byte_en.
REQ-019 In IDLE, req = 1 with opType = 00 SHALL be ignored, and all inputs SHALL be ignored when state != IDLE.
REQ-020 A request SHALL be an error when opType = 11 or addr[1:0] != 00.
REQ-021 An error request SHALL go IDLE -> RESP directly, regardless of WAIT, and drive ready = 1, err = 1, rdata = 0 with no array write.
REQ-022 A valid request SHALL go IDLE -> WAIT when WAIT > 0, and IDLE -> RESP when WAIT = 0.
REQ-023 A wait counter SHALL load 0 on acceptance, and WAIT SHALL exit to RESP on the edge where the counter equals WAIT-1.
REQ-024 The array access SHALL occur on the edge entering RESP for a valid request.
REQ-025 A write access SHALL update only the lanes whose byte_en bit is 1; byte_en = 0 SHALL produce no change.
REQ-026 A read access SHALL register the word into rdata.
REQ-027 Valid-request latency SHALL be WAIT+1 cycles from the acceptance edge to the cycle ready = 1.
REQ-028 RESP SHALL last exactly one cycle and then return to IDLE.
REQ-029 A new request SHALL be acceptable on the edge leaving RESP only if it samples state = IDLE, i.e. the earliest acceptance is the following edge.
REQ-030 Outside RESP, ready = 0, err = 0 and rdata = 0; during a write response rdata = 0.
REQ-031 A read of a word written in an earlier transaction SHALL return the merged data of that write.

Reset
REQ-032 rst = 1 on an edge SHALL force state IDLE, zero the wait counter, and drive ready = 0, busy = 0, err = 0, rdata = 0 in the next cycle.
REQ-033 rst asserted before the RESP-entry edge of a transaction SHALL abort it with no array write and no ready pulse.
REQ-034 Array contents SHALL NOT be reset.
REQ-035 rst SHALL take priority over req on the same edge.

Structure
REQ-036 A shared package mem_pkg SHALL hold the opType encodings (OP_NOP, OP_WR, OP_RD, OP_INV) and the FSM state enum.
REQ-037 Storage SHALL be a sub-module mem_array: a single-port synchronous RAM with byte enables, parameterised by N and depth.
REQ-038 The FSM, counter, request latch and error decode SHALL reside in unified_memory.

Verification
REQ-039 Defaults, write data region addr 0x08, wdata 0xDEADBEEF, byte_en 1111 -> ready pulses 3 cycles after acceptance with err = 0; a subsequent read of 0x08 returns 0xDEADBEEF.
REQ-040 Write instruction region addr 0x08, wdata 0x11111111 -> data region addr 0x08 still reads 0xDEADBEEF; instruction region addr 0x08 reads 0x11111111.
REQ-041 Partial write byte_en 0010, wdata 0x0000AB00 over 0xDEADBEEF -> read returns 0xDEADABEF.
REQ-042 opType 11, or addr 0x0A -> ready and err both high 1 cycle after acceptance, rdata = 0, array unchanged.
REQ-043 rst pulsed during WAIT of a write of 0x12345678 to 0x10 -> no ready pulse; 0x10 retains its old value; busy = 0 the cycle after reset.
REQ-044 WAIT = 0 build with back-to-back req held high -> ready every second cycle, busy toggling accordingly.
